// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - op encodings and FSM state constants for mult_div_unit
package mult_div_unit_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t CALC   = 2'd1;
  localparam state_t FINISH = 2'd2;

endpackage

// File: rtl/md_abs_neg.sv
// rtl/md_abs_neg.sv - conditional two's-complement negate
module md_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed/unsigned multiply/divide with HI/LO result registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dz_q;

  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   step_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign sign_a = op[0] & a[WIDTH-1];
  assign sign_b = op[0] & b[WIDTH-1];

  md_abs_neg #(.W(WIDTH)) u_abs_a (.val(a), .neg(sign_a), .res(mag_a));
  md_abs_neg #(.W(WIDTH)) u_abs_b (.val(b), .neg(sign_b), .res(mag_b));

  md_abs_neg #(.W(2*WIDTH)) u_fix_prod (.val(work_q), .neg(neg_res_q), .res(prod_fix));
  md_abs_neg #(.W(WIDTH)) u_fix_quo (.val(work_q[WIDTH-1:0]), .neg(neg_res_q), .res(quo_fix));
  md_abs_neg #(.W(WIDTH)) u_fix_rem (.val(work_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .res(rem_fix));

  // work_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_next = work_q;
    if (!is_div_q) begin
      step_next = {mul_sum, work_q[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      step_next = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end else begin
      step_next = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_div_q  <= op[1];
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            dz_q      <= op[1] & (b == '0);
            cnt_q     <= CNT_W'(WIDTH);
            if (op[1]) begin
              opnd_q <= mag_b;
              work_q <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd_q <= mag_a;
              work_q <= {{WIDTH{1'b0}}, mag_b};
            end
            state_q <= (op[1] && (b == '0)) ? FINISH : CALC;
          end
        end
        CALC: begin
          work_q <= step_next;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FINISH;
        end
        FINISH: begin
          done        <= 1'b1;
          div_by_zero <= dz_q;
          if (!dz_q) begin
            if (is_div_q) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one op, waits (bounded) for done and checks latency, busy span and results.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int lat, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz, input bit glitch);
    int n;
    int bc;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    n = 1;
    bc = 0;
    while (!done && n < 200) begin
      if (busy) bc++;
      if (glitch && n == 5) begin
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'h3;
      end
      if (glitch && n == 6) start = 1'b0;
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(lat - 1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
  endtask

  initial begin
    int dcount;
    checks = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    // back-to-back: second op issued in the done cycle of the first
    do_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    do_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op("div_min", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0);
    do_op("div_pos_neg", 2'b11, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op("mult_m1_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0, 32'h1, 1'b0, 1'b0);
    do_op("divu_small", 2'b10, 32'd5, 32'd9, 34, 32'd5, 32'd0, 1'b0, 1'b0);

    do_op("divu_prep", 2'b10, 32'h451, 32'h20, 34, 32'h11, 32'h22, 1'b0, 1'b0);
    do_op("divu_zero", 2'b10, 32'd100, 32'd0, 2, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    check("dz_pulse_end", 64'(div_by_zero), 64'd0);
    check("done_pulse_end", 64'(done), 64'd0);

    do_op("ignore_start", 2'b10, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b1);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    check("ignore_extra_done", 64'(dcount), 64'd0);
    check("ignore_idle_busy", 64'(busy), 64'd0);

    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFD; b = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("multu_6x7", 2'b00, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
